// File: rtl/demux_buf.sv
// ---------------------------------------------------------------------------
// demux_buf -- registered 1-to-2 demultiplexer with valid/ready handshakes.
//
// One input channel is steered word by word into one of two output channels.
// in_sel picks the channel. Each output channel has its own 2-entry FIFO, so a
// stalled consumer on one side never blocks traffic to the other side.
//
// Handshake semantics (all channels):
//   A transfer happens on a rising clk edge when valid & ready are both high.
//   A producer that raises valid holds valid and data stable until it sees
//   ready. in_ready depends only on the registered occupancy and in_sel. It
//   never depends on outk_ready, so there is no combinational path from
//   output ready to input ready.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous, active-high reset
//   in_valid/in_ready    input handshake
//   in_sel               destination channel (0 or 1)
//   in_data[WIDTH]       input word
//   out0_valid/ready     channel 0 handshake; out0_data = channel 0 head word
//   out1_valid/ready     channel 1 handshake; out1_data = channel 1 head word
//   cnt0/cnt1[16]        saturating per-channel accept counters. These ports
//                        exist only when DEMUX_STATS_EN is defined.
//   dbg_state0_o/1_o     FIFO occupancy state (0 EMPTY, 1 ONE, 2 FULL)
//
// Optional feature macro: DEMUX_STATS_EN
// ---------------------------------------------------------------------------
module demux_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
`ifdef DEMUX_STATS_EN
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
`endif
    output logic [1:0]       dbg_state0_o,
    output logic [1:0]       dbg_state1_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // Per-channel FIFO: slot0 is always the head, and slot1 holds the second
    // word when FULL. A pop from FULL shifts slot1 into slot0.
    occ_e             state_q [2];
    occ_e             state_d [2];
    logic [WIDTH-1:0] slot0_q [2];
    logic [WIDTH-1:0] slot0_d [2];
    logic [WIDTH-1:0] slot1_q [2];
    logic [WIDTH-1:0] slot1_d [2];

    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready_v;
    logic [1:0] sel_onehot;

    assign out_ready_v = {out1_ready, out0_ready};
    assign sel_onehot  = {in_sel, ~in_sel};

    assign in_ready = (state_q[in_sel] != FULL);

    assign out0_valid   = (state_q[0] != EMPTY);
    assign out1_valid   = (state_q[1] != EMPTY);
    assign out0_data    = slot0_q[0];
    assign out1_data    = slot0_q[1];
    assign dbg_state0_o = state_q[0];
    assign dbg_state1_o = state_q[1];

    // Next-state and data-path logic for both channel FIFOs
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            push[k]    = in_valid & in_ready & sel_onehot[k];
            pop[k]     = (state_q[k] != EMPTY) & out_ready_v[k];
            state_d[k] = state_q[k];
            slot0_d[k] = slot0_q[k];
            slot1_d[k] = slot1_q[k];
            case (state_q[k])
                EMPTY: begin
                    if (push[k]) begin
                        slot0_d[k] = in_data;
                        state_d[k] = ONE;
                    end
                end
                ONE: begin
                    if (push[k] && pop[k]) begin
                        // The head leaves and the new word becomes the head.
                        slot0_d[k] = in_data;
                    end else if (push[k]) begin
                        slot1_d[k] = in_data;
                        state_d[k] = FULL;
                    end else if (pop[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                FULL: begin
                    if (pop[k]) begin
                        slot0_d[k] = slot1_q[k];
                        state_d[k] = ONE;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                state_q[k] <= EMPTY;
                slot0_q[k] <= '0;
                slot1_q[k] <= '0;
            end else begin
                state_q[k] <= state_d[k];
                slot0_q[k] <= slot0_d[k];
                slot1_q[k] <= slot1_d[k];
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    // The counters stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (push[0] && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (push[1] && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_buf.sv
// ---------------------------------------------------------------------------
// Testbench for demux_buf.
//
// The bench keeps its own model: one expected queue per output channel, plus
// model counters. in_ready is predicted from the model queue depth. A word is
// pushed to its queue when the model accepts it, and the queue is popped when
// the consumer takes it.
// ---------------------------------------------------------------------------
module tb_demux_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_sel;
    logic [7:0] in_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out0_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] out1_data;
    logic [1:0] dbg_state0_o;
    logic [1:0] dbg_state1_o;
`ifdef DEMUX_STATS_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    int unsigned m_cnt0;
    int unsigned m_cnt1;
`endif

    // -------------------------------------------------------------------
    // Clock
    // -------------------------------------------------------------------
    always #5 clk = ~clk;

    demux_buf #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_data      (in_data),
        .out0_valid   (out0_valid),
        .out0_ready   (out0_ready),
        .out0_data    (out0_data),
        .out1_valid   (out1_valid),
        .out1_ready   (out1_ready),
        .out1_data    (out1_data),
`ifdef DEMUX_STATS_EN
        .cnt0         (cnt0),
        .cnt1         (cnt1),
`endif
        .dbg_state0_o (dbg_state0_o),
        .dbg_state1_o (dbg_state1_o)
    );

    // -------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------
    // Driver: one cycle of stimulus.
    // Inputs are driven at negedge and outputs are checked 1 ns later.
    // The model is then advanced to match the coming posedge.
    // -------------------------------------------------------------------
    task automatic step(input logic r, input logic v, input logic s, input logic [7:0] d,
                        input logic r0, input logic r1,
                        input logic use_tbl, input logic tbl_rdy);
        logic m_rdy;
        @(negedge clk);
        rst = r; in_valid = v; in_sel = s; in_data = d;
        out0_ready = r0; out1_ready = r1;
        #1;
        m_rdy = s ? (exp_q1.size() < 2) : (exp_q0.size() < 2);
        check("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
        if (use_tbl) check("tbl_in_ready", {31'd0, in_ready}, {31'd0, tbl_rdy});
        check("out0_valid", {31'd0, out0_valid}, {31'd0, exp_q0.size() != 0});
        check("out1_valid", {31'd0, out1_valid}, {31'd0, exp_q1.size() != 0});
        if (exp_q0.size() != 0) check("out0_data", {24'd0, out0_data}, {24'd0, exp_q0[0]});
        if (exp_q1.size() != 0) check("out1_data", {24'd0, out1_data}, {24'd0, exp_q1[0]});
        check("state0", {30'd0, dbg_state0_o}, exp_q0.size());
        check("state1", {30'd0, dbg_state1_o}, exp_q1.size());
`ifdef DEMUX_STATS_EN
        check("cnt0", {16'd0, cnt0}, m_cnt0);
        check("cnt1", {16'd0, cnt1}, m_cnt1);
`endif
        if (r) begin
            exp_q0.delete();
            exp_q1.delete();
`ifdef DEMUX_STATS_EN
            m_cnt0 = 0;
            m_cnt1 = 0;
`endif
        end else begin
            if (r0 && exp_q0.size() != 0) void'(exp_q0.pop_front());
            if (r1 && exp_q1.size() != 0) void'(exp_q1.pop_front());
            if (v && m_rdy) begin
                if (s) exp_q1.push_back(d);
                else   exp_q0.push_back(d);
`ifdef DEMUX_STATS_EN
                if (s && m_cnt1 < 32'hFFFF) m_cnt1++;
                if (!s && m_cnt0 < 32'hFFFF) m_cnt0++;
`endif
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out0_valid"}, {31'd0, out0_valid}, 32'd0);
        check({tag, "_out1_valid"}, {31'd0, out1_valid}, 32'd0);
        check({tag, "_out0_data"}, {24'd0, out0_data}, 32'd0);
        check({tag, "_out1_data"}, {24'd0, out1_data}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // -------------------------------------------------------------------
    // Directed vectors: inputs plus hand-derived in_ready
    // -------------------------------------------------------------------
    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic       r0;
        logic       r1;
        logic       rdy;
    } vec_t;

    vec_t tbl[16];

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // alternating routing, both consumers ready
        tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        // backpressure on channel 0, channel 1 keeps flowing
        tbl[4]  = '{1'b1, 1'b0, 8'hA1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 8'hA3, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        // push + pop while channel 0 holds one word
        tbl[12] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
`ifdef DEMUX_STATS_EN
        m_cnt0 = 0;
        m_cnt1 = 0;
`endif

        // Reset then idle
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 8'h00;
        out0_ready = 1'b0; out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 16; i++)
            step(1'b0, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1, 1'b1, tbl[i].rdy);

        // Mid-operation reset: both FIFOs full, then reset with live handshakes
        step(1'b0, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hD2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
        #1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef DEMUX_STATS_EN
        // Accept counters: 5 words to channel 1, then saturation
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b1, 8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("cnt1_after5", {16'd0, cnt1}, 32'd5);
        check("cnt0_after5", {16'd0, cnt0}, 32'd0);
        for (int i = 0; i < 65540; i++)
            step(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("cnt1_sat", {16'd0, cnt1}, 32'h0000FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
